// File: rtl/mdu_ctrl_if.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_if
//   Bundles the E-stage issue signals and the HI/LO result/status signals that
//   connect the pipeline to the multiply/divide sequencer (mdu_ctrl).
//
//   Optional feature macro: MDU_CANCEL_EN (adds the cancel flush input).
//
//   Signals
//     start      E-stage MD instruction valid this cycle
//     md_op[2:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//     operand_a  forwarded Rs value
//     operand_b  forwarded Rt value
//     md_use_D   D-stage instruction reads or writes HI/LO
//     cancel     exception/flush (only with MDU_CANCEL_EN)
//     busy       multi-cycle operation in flight
//     stall_md   combinational D-stage stall request
//     done       one-cycle pulse after a HI/LO commit
//     hi, lo     architectural HI/LO
//     dbg_state  sequencer FSM state (0 IDLE, 1 RUN) for observation
//
//   Modports: master = pipeline side, slave = mdu_ctrl side.
// -----------------------------------------------------------------------------
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        md_use_D;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    logic        busy;
    logic        stall_md;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbg_state;

`ifdef MDU_CANCEL_EN
    modport master (
        output start, md_op, operand_a, operand_b, md_use_D, cancel,
        input  busy, stall_md, done, hi, lo, dbg_state
    );
    modport slave (
        input  start, md_op, operand_a, operand_b, md_use_D, cancel,
        output busy, stall_md, done, hi, lo, dbg_state
    );
`else
    modport master (
        output start, md_op, operand_a, operand_b, md_use_D,
        input  busy, stall_md, done, hi, lo, dbg_state
    );
    modport slave (
        input  start, md_op, operand_a, operand_b, md_use_D,
        output busy, stall_md, done, hi, lo, dbg_state
    );
`endif
endinterface

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//   Multiply/divide sequencer owning the architectural HI/LO registers.
//   An MD operation issued from E is computed immediately into shadow
//   registers; a down-counter then models the multi-cycle latency and the
//   shadow values are committed to HI/LO when the counter expires.
//
//   Optional feature macro: MDU_CANCEL_EN
//     defined   : bus.cancel aborts an in-flight operation (no commit, no done)
//                 and suppresses accept / mthi / mtlo in IDLE.
//     undefined : no cancel input; operations always run to completion.
//
//   Parameters
//     MULT_CYCLES  accept-to-commit latency for mult/multu (>=1)
//     DIV_CYCLES   accept-to-commit latency for div/divu  (>=1)
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-low
//     bus    mdu_ctrl_if.slave (issue inputs, busy/stall_md/done/hi/lo out)
//
//   Handshake: start is a valid qualifier with no ready return path. The
//   upstream pipeline uses stall_md (asserted for any HI/LO user while an
//   operation is accepted or in flight) so that start never arrives in RUN;
//   a start seen in RUN is ignored.
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      shadow_hi_q, shadow_hi_d;
    logic [31:0]      shadow_lo_q, shadow_lo_d;
    // Set when the accepted operation was a divide by zero: the commit edge
    // then leaves HI/LO untouched while still pulsing done.
    logic             keep_q, keep_d;

    logic cancel_w;
`ifdef MDU_CANCEL_EN
    assign cancel_w = bus.cancel;
`else
    assign cancel_w = 1'b0;
`endif

    logic is_mult, is_div, is_md;
    assign is_mult = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);
    assign is_div  = (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);
    assign is_md   = is_mult || is_div;

    // ------------------------------------------------------------------
    // Arithmetic (single-cycle combinational; latency is modelled by cnt)
    // ------------------------------------------------------------------
    logic [63:0] mul_s, mul_u;
    logic        div_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] uq, ur;
    logic [31:0] div_q, div_r;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        mul_s = {{32{bus.operand_a[31]}}, bus.operand_a}
              * {{32{bus.operand_b[31]}}, bus.operand_b};
        mul_u = {32'd0, bus.operand_a} * {32'd0, bus.operand_b};

        // Signed divide runs on magnitudes so the 0x80000000 / -1 case
        // falls out naturally (magnitude 0x80000000, quotient not negated).
        div_signed = (bus.md_op == OP_DIV);
        a_neg      = div_signed && bus.operand_a[31];
        b_neg      = div_signed && bus.operand_b[31];
        a_mag      = a_neg ? (~bus.operand_a + 32'd1) : bus.operand_a;
        b_mag      = b_neg ? (~bus.operand_b + 32'd1) : bus.operand_b;

        if (b_mag != 32'd0) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end else begin
            uq = 32'd0;
            ur = 32'd0;
        end

        div_q = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        div_r = a_neg ? (~ur + 32'd1) : ur;

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (bus.md_op)
            OP_MULT:  begin res_hi = mul_s[63:32]; res_lo = mul_s[31:0]; end
            OP_MULTU: begin res_hi = mul_u[63:32]; res_lo = mul_u[31:0]; end
            OP_DIV,
            OP_DIVU:  begin res_hi = div_r;        res_lo = div_q;       end
            default:  begin res_hi = 32'd0;        res_lo = 32'd0;       end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        keep_d      = keep_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !cancel_w) begin
                    if (is_md) begin
                        shadow_hi_d = res_hi;
                        shadow_lo_d = res_lo;
                        keep_d      = is_div && (bus.operand_b == 32'd0);
                        cnt_d       = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        busy_d      = 1'b1;
                        state_d     = S_RUN;
                    end else if (bus.md_op == OP_MTHI) begin
                        hi_d = bus.operand_a;
                    end else if (bus.md_op == OP_MTLO) begin
                        lo_d = bus.operand_a;
                    end
                end
            end
            S_RUN: begin
                // start is ignored here; upstream holds it off via stall_md.
                if (cancel_w) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    if (!keep_q) begin
                        hi_d = shadow_hi_q;
                        lo_d = shadow_lo_q;
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            shadow_hi_q <= 32'd0;
            shadow_lo_q <= 32'd0;
            keep_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            keep_q      <= keep_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The start term covers the accept cycle, before busy has risen.
    assign bus.stall_md  = bus.md_use_D && (busy_q || (bus.start && is_md));
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_ctrl_if bus ();

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic int latency(input logic [2:0] op);
    return (op == 3'd1 || op == 3'd2) ? 5 : 10;
  endfunction

  // Reference model: architectural result of one MD op from plain
  // 64-bit arithmetic. Divide by zero leaves HI/LO as they were.
  task automatic model_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          output logic [31:0] new_hi, output logic [31:0] new_lo);
    longint sa, sb, prod, q, r;
    logic [63:0] up;
    new_hi = old_hi;
    new_lo = old_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin prod = sa * sb; new_hi = prod[63:32]; new_lo = prod[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; new_hi = up[63:32]; new_lo = up[31:0]; end
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; new_hi = r[31:0]; new_lo = q[31:0]; end
      3'd4: if (b != 0) begin new_hi = a % b; new_lo = a / b; end
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.md_op     = 3'd0;
    bus.operand_a = 32'd0;
    bus.operand_b = 32'd0;
    bus.md_use_D  = 1'b0;
  endtask

  // Issue a mult/div and follow it to completion.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d);
    int n;
    logic [31:0] nh, nl;
    n = latency(op);
    model_md(op, a, b, exp_hi, exp_lo, nh, nl);
    bus.start = 1'b1; bus.md_op = op; bus.operand_a = a; bus.operand_b = b; bus.md_use_D = use_d;
    settle();
    chk("stall_accept", bus.stall_md, use_d);
    tick();
    bus.start = 1'b0;
    settle();
    for (int k = 0; k < n; k++) begin
      chk("busy_run", bus.busy, 1'b1);
      chk("done_run", bus.done, 1'b0);
      chk("stall_run", bus.stall_md, use_d);
      chk("hi_hold", bus.hi, exp_hi);
      chk("lo_hold", bus.lo, exp_lo);
      tick();
    end
    exp_hi = nh;
    exp_lo = nl;
    chk("busy_end", bus.busy, 1'b0);
    chk("done_pulse", bus.done, 1'b1);
    chk("stall_done", bus.stall_md, 1'b0);
    chk("hi_commit", bus.hi, exp_hi);
    chk("lo_commit", bus.lo, exp_lo);
    bus.md_use_D = 1'b0;
    tick();
    chk("done_single", bus.done, 1'b0);
  endtask

  // mthi/mtlo or a no-op issue: single-edge effect, never busy.
  task automatic run_single(input logic [2:0] op, input logic [31:0] a, input logic use_d);
    bus.start = 1'b1; bus.md_op = op; bus.operand_a = a; bus.operand_b = $urandom; bus.md_use_D = use_d;
    settle();
    chk("stall_single", bus.stall_md, 1'b0);
    tick();
    bus.start = 1'b0; bus.md_use_D = 1'b0;
    if (op == 3'd5) exp_hi = a;
    if (op == 3'd6) exp_lo = a;
    chk("busy_single", bus.busy, 1'b0);
    chk("done_single_op", bus.done, 1'b0);
    chk("hi_single", bus.hi, exp_hi);
    chk("lo_single", bus.lo, exp_lo);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    checks = 0;
    errors = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    idle_inputs();
`ifdef MDU_CANCEL_EN
    bus.cancel = 1'b0;
`endif

    // Reset held for two edges with a mult offered.
    reset = 1'b0;
    bus.start = 1'b1; bus.md_op = 3'd1; bus.operand_a = 32'd3; bus.operand_b = 32'd3;
    tick();
    tick();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_state", bus.dbg_state, 1'b0);
    idle_inputs();
    reset = 1'b1;
    tick();

    // Basic mult, signed/unsigned divides, overflow divide.
    run_md(3'd1, 32'h0001_0000, 32'h0001_0000, 1'b0);
    chk("mult_hi_const", bus.hi, 32'h0000_0001);
    chk("mult_lo_const", bus.lo, 32'h0000_0000);
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo_const", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi_const", bus.hi, 32'hFFFF_FFFF);
    run_md(3'd4, 32'd7, 32'd2, 1'b0);
    chk("divu_lo_const", bus.lo, 32'd3);
    chk("divu_hi_const", bus.hi, 32'd1);
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("ovf_lo_const", bus.lo, 32'h8000_0000);
    chk("ovf_hi_const", bus.hi, 32'd0);

    // Divide by zero keeps preloaded HI/LO.
    run_single(3'd5, 32'h11, 1'b0);
    run_single(3'd6, 32'h22, 1'b0);
    run_md(3'd3, 32'd1234, 32'd0, 1'b0);
    chk("dz_hi_const", bus.hi, 32'h11);
    chk("dz_lo_const", bus.lo, 32'h22);

    // Stall with and without a D-stage HI/LO user.
    run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_md(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    // Start held across the commit edge: ignored there, accepted next edge.
    bus.start = 1'b1; bus.md_op = 3'd1; bus.operand_a = 32'd6; bus.operand_b = 32'd7;
    tick();
    for (int k = 0; k < 5; k++) tick();
    chk("cs_busy_commit", bus.busy, 1'b0);
    chk("cs_done_commit", bus.done, 1'b1);
    chk("cs_lo_commit", bus.lo, 32'd42);
    tick();
    chk("cs_busy_reaccept", bus.busy, 1'b1);
    chk("cs_state_reaccept", bus.dbg_state, 1'b1);
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("cs_done_second", bus.done, 1'b1);
    exp_hi = 32'd0;
    exp_lo = 32'd42;
    tick();

    // Reset during the 3rd busy cycle of a divide.
    bus.start = 1'b1; bus.md_op = 3'd4; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    chk("mr_busy", bus.busy, 1'b0);
    chk("mr_hi", bus.hi, 32'd0);
    chk("mr_lo", bus.lo, 32'd0);
    chk("mr_done", bus.done, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("mr_no_done", bus.done, 1'b0);
    end

    // Cancel in the 2nd busy cycle (or plain completion without the feature).
    run_single(3'd6, 32'h55, 1'b0);
`ifdef MDU_CANCEL_EN
    bus.start = 1'b1; bus.md_op = 3'd1; bus.operand_a = 32'd3; bus.operand_b = 32'd4;
    tick();
    bus.start = 1'b0;
    tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("cancel_busy", bus.busy, 1'b0);
    chk("cancel_lo", bus.lo, exp_lo);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("cancel_no_done", bus.done, 1'b0);
      chk("cancel_lo_keep", bus.lo, exp_lo);
    end
`else
    run_md(3'd1, 32'd3, 32'd4, 1'b0);
    chk("mult12_lo", bus.lo, 32'd12);
`endif

    // Randomized issue mix against the model.
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) begin
        a = 32'($urandom_range(0, 200)) - 32'd100;
        b = 32'($urandom_range(0, 20)) - 32'd10;
      end
      if (op >= 3'd1 && op <= 3'd4)
        run_md(op, a, b, 1'($urandom_range(0, 1)));
      else
        run_single(op, a, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
